// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array ofmap drain path.
package systolic_pkg;

    localparam int OFMAP_WIDTH_DEF = 32;
    localparam int ARRAY_WIDTH_DEF = 4;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int CNT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} drain_state_e;

    typedef logic signed [OFMAP_WIDTH_DEF-1:0] ofmap_row_t [ARRAY_WIDTH_DEF-1:0];

endpackage

// File: rtl/ofmap_drain_if.sv
// Skewed ofmap input stream and aligned output row stream of the drain block.
interface ofmap_drain_if
    import systolic_pkg::*;
#(
    parameter int OFMAP_WIDTH = OFMAP_WIDTH_DEF,
    parameter int ARRAY_WIDTH = ARRAY_WIDTH_DEF
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic signed [OFMAP_WIDTH-1:0] ofmap_in [ARRAY_WIDTH-1:0];
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OFMAP_WIDTH-1:0] out_row  [ARRAY_WIDTH-1:0];

    // slave: the drain block; master: array side plus output buffer
    modport slave  (input  in_valid, ofmap_in, out_ready,
                    output in_ready, out_valid, out_row);
    modport master (output in_valid, ofmap_in, out_ready,
                    input  in_ready, out_valid, out_row);

endinterface

// File: rtl/ofmap_drain_sync_fifo.sv
// Row-wide synchronous FIFO with exact full/empty and an occupancy count.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // a pop in the same cycle frees the slot a push needs when full
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofmap_drain.sv
// Deskews column-skewed ofmap rows, buffers them and streams aligned rows out.
// Build option: OFMAP_RELU_EN clamps negative elements to zero before the FIFO.
module ofmap_drain
    import systolic_pkg::*;
#(
    parameter int OFMAP_WIDTH = OFMAP_WIDTH_DEF,
    parameter int ARRAY_WIDTH = ARRAY_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_rows,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    ofmap_drain_if.slave         bus
);

    localparam int PIPE  = ARRAY_WIDTH - 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_W = OFMAP_WIDTH * ARRAY_WIDTH;

    drain_state_e state, state_nxt;

    logic [CNT_WIDTH-1:0]          num_rows_q;
    logic [CNT_WIDTH-1:0]          rows_in;
    logic [CNT_WIDTH-1:0]          rows_out;
    logic [PIPE-1:0]               vld_p;
    logic [CW-1:0]                 fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          in_ready;
    logic                          accept;
    logic                          pop;
    logic signed [OFMAP_WIDTH-1:0] dsk_out [ARRAY_WIDTH];
    logic signed [OFMAP_WIDTH-1:0] row_p0  [ARRAY_WIDTH];
    logic [ROW_W-1:0]              push_data;
    logic [ROW_W-1:0]              pop_data;

    function automatic int popcount(input logic [PIPE-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < PIPE; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

`ifdef OFMAP_RELU_EN
    function automatic logic signed [OFMAP_WIDTH-1:0] relu(input logic signed [OFMAP_WIDTH-1:0] x);
        return x[OFMAP_WIDTH-1] ? '0 : x;
    endfunction
`endif

    // The array cannot stall, so rows already in the deskew pipe reserve FIFO space.
    assign in_ready = (state == DRAIN) && (rows_in != num_rows_q) && !fifo_full &&
                      ((int'(fifo_count) + popcount(vld_p)) < FIFO_DEPTH);
    assign accept       = bus.in_valid && in_ready;
    assign pop          = bus.out_valid && bus.out_ready;
    assign bus.in_ready = in_ready;
    assign bus.out_valid = !fifo_empty;

    // Deskew stage: column j waits ARRAY_WIDTH-1-j cycles so all columns meet.
    for (genvar j = 0; j < ARRAY_WIDTH; j++) begin : g_col
        localparam int D = ARRAY_WIDTH - 1 - j;
        if (D == 0) begin : g_direct
            assign dsk_out[j] = bus.ofmap_in[j];
        end else begin : g_dly
            logic signed [OFMAP_WIDTH-1:0] dsk_p [D];
            always_ff @(posedge clk) begin
                dsk_p[0] <= bus.ofmap_in[j];
                for (int k = 1; k < D; k++) begin
                    dsk_p[k] <= dsk_p[k-1];
                end
            end
            assign dsk_out[j] = dsk_p[D-1];
        end
`ifdef OFMAP_RELU_EN
        assign row_p0[j] = relu(dsk_out[j]);
`else
        assign row_p0[j] = dsk_out[j];
`endif
    end

    always_comb begin
        push_data = '0;
        for (int j = 0; j < ARRAY_WIDTH; j++) begin
            push_data[j*OFMAP_WIDTH +: OFMAP_WIDTH] = row_p0[j];
        end
    end

    // FIFO stage: aligned rows are pushed when the delayed valid emerges.
    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ROW_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p[PIPE-1]),
        .pop   (pop),
        .wdata (push_data),
        .rdata (pop_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        bus.out_row = '{default: '0};
        for (int j = 0; j < ARRAY_WIDTH; j++) begin
            bus.out_row[j] = fifo_empty ? '0 : $signed(pop_data[j*OFMAP_WIDTH +: OFMAP_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_rows_q <= '0;
            rows_in    <= '0;
            rows_out   <= '0;
            vld_p      <= '0;
            overflow   <= 1'b0;
        end else begin
            vld_p[0] <= accept;
            for (int k = 1; k < PIPE; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            if (bus.in_valid && !in_ready) overflow <= 1'b1;
            if (state == IDLE && start) begin
                num_rows_q <= num_rows;
                rows_in    <= '0;
                rows_out   <= '0;
            end else begin
                if (accept) rows_in  <= rows_in + CNT_WIDTH'(1);
                if (pop)    rows_out <= rows_out + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:  if (start) state_nxt = (num_rows == '0) ? DONE : DRAIN;
            DRAIN: if (rows_in == num_rows_q) state_nxt = FLUSH;
            FLUSH: if (rows_out == num_rows_q && fifo_empty && vld_p == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ofmap_drain.sv
// Randomized bench for ofmap_drain with a queue-based reference model.
module tb_ofmap_drain;
    import systolic_pkg::*;

    localparam int W     = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_rows = '0;
    logic          busy, done, overflow;

    ofmap_drain_if #(.OFMAP_WIDTH(W), .ARRAY_WIDTH(AW)) bus ();

    ofmap_drain #(
        .OFMAP_WIDTH (W),
        .ARRAY_WIDTH (AW),
        .FIFO_DEPTH  (DEPTH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_rows (num_rows),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    ofmap_row_t exp_q [$];
    int         exp_t [$];
    bit         m_act = 0;
    bit         m_ovf = 0;
    int         m_n = 0, m_acc = 0, m_pop = 0, m_done_cyc = -1;
    int         cyc = 0;

    // stimulus history: row issued k cycles ago
    ofmap_row_t hist_r [AW];
    bit         hist_v [AW];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [AW*W-1:0] pack(input ofmap_row_t r);
        logic [AW*W-1:0] v;
        for (int j = 0; j < AW; j++) v[j*W +: W] = r[j];
        return v;
    endfunction

    function automatic ofmap_row_t model_row(input ofmap_row_t r);
        ofmap_row_t o;
        for (int j = 0; j < AW; j++) begin
`ifdef OFMAP_RELU_EN
            o[j] = (r[j] < 0) ? '0 : r[j];
`else
            o[j] = r[j];
`endif
        end
        return o;
    endfunction

    function automatic ofmap_row_t rand_row();
        ofmap_row_t r;
        for (int j = 0; j < AW; j++) r[j] = $urandom;
        return r;
    endfunction

    // Compare process: checks outputs, then advances the model to the next edge.
    always @(negedge clk) begin
        bit exp_ir, exp_ov, was_act;
        cyc++;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_out_row", pack(bus.out_row), 0);
            exp_q.delete();
            exp_t.delete();
            m_act = 0; m_ovf = 0; m_n = 0; m_acc = 0; m_pop = 0; m_done_cyc = -1;
        end else begin
            exp_ir = m_act && (m_acc < m_n) && ((m_acc - m_pop) < DEPTH);
            exp_ov = (exp_q.size() > 0) && (exp_t[0] <= cyc);
            chk("in_ready", bus.in_ready, exp_ir);
            chk("out_valid", bus.out_valid, exp_ov);
            chk("busy", busy, m_act);
            chk("done", done, m_act && (cyc == m_done_cyc));
            chk("overflow", overflow, m_ovf);
            if (exp_ov) chk("out_row", pack(bus.out_row), pack(exp_q[0]));

            if (bus.in_valid && !exp_ir) m_ovf = 1;
            if (bus.in_valid && exp_ir) begin
                exp_q.push_back(model_row(hist_r[0]));
                exp_t.push_back(cyc + AW);
                m_acc++;
            end
            if (exp_ov && bus.out_ready) begin
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
                m_pop++;
                if (m_pop == m_n) m_done_cyc = cyc + 2;
            end
            was_act = m_act;
            if (m_act && cyc == m_done_cyc) m_act = 0;
            if (start && !was_act) begin
                m_act = 1;
                m_n   = int'(num_rows);
                m_acc = 0;
                m_pop = 0;
                m_done_cyc = (num_rows == '0) ? cyc + 1 : -1;
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic drive(input bit iv, input ofmap_row_t r, input bit ordy,
                         input bit st, input int n, input bit honour);
        @(posedge clk);
        #1;
        if (honour) iv = iv && bus.in_ready;
        for (int k = AW - 1; k > 0; k--) begin
            hist_v[k] = hist_v[k-1];
            hist_r[k] = hist_r[k-1];
        end
        hist_v[0] = iv;
        hist_r[0] = r;
        for (int j = 0; j < AW; j++) begin
            bus.ofmap_in[j] = hist_v[j] ? hist_r[j][j] : $signed($urandom);
        end
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        start         = st;
        num_rows      = CW'(n);
    endtask

    // mode 0: honour in_ready, out_ready=1, stray start mid-job
    // mode 1: honour in_ready, random out_ready
    // mode 2: honour in_ready, out_ready held low for 10 cycles
    // mode 3: in_valid forced regardless of in_ready, out_ready low for 8 cycles
    task automatic run_job(input int n, input int mode);
        int  budget;
        bit  ordy, st, seen_full;
        budget = 0;
        seen_full = 0;
        drive(0, rand_row(), 1, 1, n, 0);
        do begin
            ordy = 1;
            st   = 0;
            case (mode)
                0: st = (budget == 2);
                1: ordy = 1'($urandom_range(0, 1));
                2: ordy = (budget >= 10);
                3: ordy = (budget >= 8);
                default: ordy = 1;
            endcase
            drive(m_acc < n, rand_row(), ordy, st, n + 3, mode != 3);
            if (mode == 2 && !seen_full && (m_acc - m_pop) == DEPTH) begin
                chk("in_ready_full", bus.in_ready, 0);
                seen_full = 1;
            end
            budget++;
        end while ((m_act || budget < 2) && budget < 400);
        if (budget >= 400) chk("job_timeout", 1, 0);
        drive(0, rand_row(), 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 0;
        start = 0;
        rst_n = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_in_ready", bus.in_ready, 0);
        chk("async_rst_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        for (int k = 0; k < AW; k++) hist_v[k] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ofmap_row_t r, e;
        bus.in_valid  = 0;
        bus.out_ready = 0;
        for (int j = 0; j < AW; j++) bus.ofmap_in[j] = '0;
        for (int k = 0; k < AW; k++) begin
            hist_v[k] = 0;
            hist_r[k] = rand_row();
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;

        // single row 1,2,3,4: visible 4 cycles after column 0, done 2 cycles later
        for (int j = 0; j < AW; j++) r[j] = j + 1;
        drive(0, rand_row(), 1, 1, 1, 0);
        drive(1, r, 1, 0, 0, 0);
        repeat (3) drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t2_not_yet_valid", bus.out_valid, 0);
        drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t2_valid", bus.out_valid, 1);
        chk("t2_row", pack(bus.out_row), {32'sd4, 32'sd3, 32'sd2, 32'sd1});
        drive(0, rand_row(), 1, 0, 0, 0);
        drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t2_done", done, 1);
        drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t2_done_gone", done, 0);
        chk("t2_busy_low", busy, 0);

        // eight back-to-back rows
        run_job(8, 0);
        chk("t3_no_overflow", overflow, 0);
        chk("t3_busy_low", busy, 0);

        // randomized backpressure
        for (int i = 0; i < 4; i++) run_job($urandom_range(1, 12), 1);

        // stalled output buffer
        run_job(7, 2);

        // reset mid-drain, then restart
        drive(0, rand_row(), 1, 1, 5, 0);
        drive(1, rand_row(), 1, 0, 0, 1);
        drive(1, rand_row(), 1, 0, 0, 1);
        @(posedge clk);
        #1;
        do_reset();
        repeat (3) drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t1_no_done_after_rst", done, 0);
        run_job(3, 0);

        // forced beats while not ready
        run_job(6, 3);
        chk("t5_overflow_set", overflow, 1);
        repeat (3) drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t5_overflow_sticky", overflow, 1);

        @(posedge clk);
        #1;
        do_reset();

        // sign handling of {-5,7,0,-1}
        r[0] = -5; r[1] = 7; r[2] = 0; r[3] = -1;
`ifdef OFMAP_RELU_EN
        e[0] = 0;  e[1] = 7; e[2] = 0; e[3] = 0;
`else
        e[0] = -5; e[1] = 7; e[2] = 0; e[3] = -1;
`endif
        drive(0, rand_row(), 1, 1, 1, 0);
        drive(1, r, 1, 0, 0, 0);
        repeat (4) drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t6_valid", bus.out_valid, 1);
        chk("t6_row", pack(bus.out_row), pack(e));
        repeat (3) drive(0, rand_row(), 1, 0, 0, 0);

        // zero-row job
        drive(0, rand_row(), 1, 1, 0, 0);
        drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t6_zero_done", done, 1);
        drive(0, rand_row(), 1, 0, 0, 0);
        #1;
        chk("t6_zero_done_gone", done, 0);
        chk("t6_zero_busy_low", busy, 0);

        for (int i = 0; i < 3; i++) run_job($urandom_range(4, 10), 1);
        repeat (2) drive(0, rand_row(), 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
